// File: rtl/idu_pkg.sv
// idu_pkg: shared definitions for the decode stage.
//   - RV32 major opcode constants
//   - ALU operation codes and CSR operation codes
//   - bit positions inside the 12-bit control flag vector
//   - dec_t: decoded control bundle, entry_t: dec_t plus its pc
// Register-index fields are always 5 bits wide here; the stage narrows them
// to the configured index width at its outputs.
package idu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RW   = 2'd1;
  localparam logic [1:0] CSR_RS   = 2'd2;
  localparam logic [1:0] CSR_RC   = 2'd3;

  localparam int F_REG_WRITE  = 11;
  localparam int F_MEM_READ   = 10;
  localparam int F_MEM_WRITE  = 9;
  localparam int F_MEM_TO_REG = 8;
  localparam int F_BRANCH     = 7;
  localparam int F_JAL        = 6;
  localparam int F_JALR       = 5;
  localparam int F_AUIPC      = 4;
  localparam int F_FENCE      = 3;
  localparam int F_ECALL      = 2;
  localparam int F_EBREAK     = 1;
  localparam int F_MRET       = 0;

  // Flags that must never take effect for an illegal instruction:
  // reg_write, mem_read, mem_write, branch, jal, jalr.
  localparam logic [11:0] ILLEGAL_KILL = 12'b1110_1110_0000;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [2:0]  br_op;
    logic [2:0]  mem_size;
    logic [11:0] flags;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        dec;
  } entry_t;

endpackage

// File: rtl/idu_if.sv
// idu_if: IFU->IDU request channel and IDU->EXU decoded-entry channel.
//   Parameters: XLEN (pc/imm width), AW (register index width).
//   modport master: environment side (drives in_*, out_ready).
//   modport slave : decode stage side (drives in_ready, out_*).
interface idu_if #(
  parameter int XLEN = 32,
  parameter int AW   = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [AW-1:0]   out_rs1;
  logic [AW-1:0]   out_rs2;
  logic [AW-1:0]   out_rd;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_op;
  logic            out_alu_src;
  logic [2:0]      out_br_op;
  logic [2:0]      out_mem_size;
  logic [11:0]     out_flags;
  logic [1:0]      out_csr_op;
  logic            out_csr_imm;
  logic            out_csr_we;
  logic [11:0]     out_csr_addr;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_alu_src, out_br_op, out_mem_size, out_flags,
           out_csr_op, out_csr_imm, out_csr_we, out_csr_addr, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_alu_src, out_br_op, out_mem_size, out_flags,
           out_csr_op, out_csr_imm, out_csr_we, out_csr_addr, out_illegal
  );
endinterface

// File: rtl/idu_dec.sv
// idu_dec: purely combinational RV32I/E + Zicsr + FENCE decoder.
//   inst : 32-bit instruction word
//   dec  : decoded control bundle (dec_t); illegal encodings are reported in
//          dec.illegal with side-effecting flags suppressed.
//   NR_REGS = 16 rejects any used register field that names x16..x31.
module idu_dec
  import idu_pkg::*;
#(
  parameter int NR_REGS = 16
) (
  input  logic [31:0] inst,
  output dec_t        dec
);

  localparam bit RV32E = (NR_REGS == 16);

  logic [6:0]  opcode_s;
  logic [6:0]  funct7_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic        f7_zero_s;
  logic        f7_alt_s;
  logic [3:0]  arith_op_s;
  logic        use_rd_s;
  logic        use_rs1_s;
  logic        use_rs2_s;
  logic        bad_enc_s;
  logic        reg_err_s;
  logic        illegal_s;

  assign opcode_s  = inst[6:0];
  assign rd_s      = inst[11:7];
  assign funct3_s  = inst[14:12];
  assign rs1_s     = inst[19:15];
  assign rs2_s     = inst[24:20];
  assign funct7_s  = inst[31:25];
  assign imm_i_s   = {{20{inst[31]}}, inst[31:20]};
  assign imm_s_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b_s   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u_s   = {inst[31:12], 12'h000};
  assign imm_j_s   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign f7_zero_s = (funct7_s == 7'b0000000);
  assign f7_alt_s  = (funct7_s == 7'b0100000);

  // ALU op for OP / OP-IMM; SUB exists only in register form (ADDI bit 30 is immediate)
  always_comb begin
    arith_op_s = ALU_ADD;
    case (funct3_s)
      3'b000: arith_op_s = (f7_alt_s && (opcode_s == OP_REG)) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op_s = ALU_SLL;
      3'b010: arith_op_s = ALU_SLT;
      3'b011: arith_op_s = ALU_SLTU;
      3'b100: arith_op_s = ALU_XOR;
      3'b101: arith_op_s = f7_alt_s ? ALU_SRA : ALU_SRL;
      3'b110: arith_op_s = ALU_OR;
      3'b111: arith_op_s = ALU_AND;
      default: arith_op_s = ALU_ADD;
    endcase
  end

  // Main decode: per-opcode fields, then legality and flag suppression
  always_comb begin
    dec       = '0;
    dec.rs1   = rs1_s;
    dec.rs2   = rs2_s;
    dec.rd    = rd_s;
    use_rd_s  = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    bad_enc_s = 1'b0;
    case (opcode_s)
      OP_LUI: begin
        dec.imm = imm_u_s; dec.alu_op = ALU_PASSB; dec.alu_src = 1'b1;
        dec.flags[F_REG_WRITE] = 1'b1; use_rd_s = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = imm_u_s; dec.alu_src = 1'b1;
        dec.flags[F_REG_WRITE] = 1'b1; dec.flags[F_AUIPC] = 1'b1; use_rd_s = 1'b1;
      end
      OP_JAL: begin
        dec.imm = imm_j_s; dec.alu_src = 1'b1;
        dec.flags[F_REG_WRITE] = 1'b1; dec.flags[F_JAL] = 1'b1; use_rd_s = 1'b1;
      end
      OP_JALR: begin
        dec.imm = imm_i_s; dec.alu_src = 1'b1;
        dec.flags[F_REG_WRITE] = 1'b1; dec.flags[F_JALR] = 1'b1;
        use_rd_s = 1'b1; use_rs1_s = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm = imm_b_s; dec.br_op = funct3_s; dec.flags[F_BRANCH] = 1'b1;
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
        bad_enc_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      end
      OP_LOAD: begin
        dec.imm = imm_i_s; dec.alu_src = 1'b1; dec.mem_size = funct3_s;
        dec.flags[F_REG_WRITE] = 1'b1; dec.flags[F_MEM_READ] = 1'b1;
        dec.flags[F_MEM_TO_REG] = 1'b1; use_rd_s = 1'b1; use_rs1_s = 1'b1;
        bad_enc_s = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
      end
      OP_STORE: begin
        dec.imm = imm_s_s; dec.alu_src = 1'b1; dec.mem_size = funct3_s;
        dec.flags[F_MEM_WRITE] = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
        bad_enc_s = (funct3_s > 3'b010);
      end
      OP_IMM: begin
        dec.imm = imm_i_s; dec.alu_src = 1'b1; dec.alu_op = arith_op_s;
        dec.flags[F_REG_WRITE] = 1'b1; use_rd_s = 1'b1; use_rs1_s = 1'b1;
        // only shifts carry a funct7 field in immediate form
        bad_enc_s = ((funct3_s == 3'b001) && !f7_zero_s) ||
                    ((funct3_s == 3'b101) && !f7_zero_s && !f7_alt_s);
      end
      OP_REG: begin
        dec.alu_op = arith_op_s; dec.flags[F_REG_WRITE] = 1'b1;
        use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
        bad_enc_s = !(f7_zero_s ||
                      (f7_alt_s && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      end
      OP_FENCE: begin
        dec.imm = imm_i_s; dec.flags[F_FENCE] = 1'b1;
      end
      OP_SYSTEM: begin
        if (funct3_s == 3'b000) begin
          case (inst[31:20])
            12'h000: dec.flags[F_ECALL]  = 1'b1;
            12'h001: dec.flags[F_EBREAK] = 1'b1;
            12'h302: dec.flags[F_MRET]   = 1'b1;
            default: bad_enc_s = 1'b1;
          endcase
        end else if (funct3_s == 3'b100) begin
          bad_enc_s = 1'b1;
        end else begin
          // funct3[2] selects the uimm form; funct3[1:0] is the CSR op code
          dec.csr_op   = funct3_s[1:0];
          dec.csr_imm  = funct3_s[2];
          dec.csr_addr = inst[31:20];
          dec.alu_op   = ALU_PASSB;
          dec.alu_src  = funct3_s[2];
          dec.imm      = funct3_s[2] ? {27'd0, rs1_s} : 32'd0;
          dec.csr_we   = (funct3_s[1:0] == CSR_RW) || (rs1_s != 5'd0);
          dec.flags[F_REG_WRITE] = 1'b1;
          use_rd_s  = 1'b1;
          use_rs1_s = !funct3_s[2];
        end
      end
      default: bad_enc_s = 1'b1;
    endcase

    reg_err_s = RV32E && ((use_rd_s && rd_s[4]) || (use_rs1_s && rs1_s[4]) ||
                          (use_rs2_s && rs2_s[4]));
    illegal_s   = bad_enc_s || reg_err_s;
    dec.illegal = illegal_s;
    dec.flags   = dec.flags & ~(illegal_s ? ILLEGAL_KILL : 12'h000);
    dec.flags[F_REG_WRITE] = dec.flags[F_REG_WRITE] & (rd_s != 5'd0);
    dec.csr_we  = dec.csr_we & ~illegal_s;
  end

endmodule

// File: rtl/idu_stage.sv
// idu_stage: registered decode stage with a 2-entry (output + skid) buffer.
//   clk, rst : clock, synchronous active-high reset
//   flush    : drops both buffered entries and any same-cycle accept
//   bus      : idu_if.slave -- in_valid/in_ready/in_pc/in_inst request,
//              out_valid/out_ready plus decoded payload toward the EXU
//   perf_dec_cnt, perf_stall_cnt : present only when IDU_PERF_EN is defined
// in_ready comes straight from the skid-valid flop and out_* straight from
// the output register, so neither side sees a combinational path.
module idu_stage
  import idu_pkg::*;
#(
  parameter int NR_REGS = 16,
  parameter int XLEN    = 32
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  idu_if.slave   bus
`ifdef IDU_PERF_EN
  ,
  output logic [31:0] perf_dec_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int AW = $clog2(NR_REGS);

  dec_t   dec_s;
  entry_t in_entry_s;
  entry_t out_r;
  entry_t skid_r;
  logic   out_valid_r;
  logic   skid_valid_r;
  logic   accept_s;
  logic   out_free_s;
  logic   unused_reg_bits_s;

  idu_dec #(.NR_REGS(NR_REGS)) u_dec (
    .inst (bus.in_inst),
    .dec  (dec_s)
  );

  assign in_entry_s = {bus.in_pc, dec_s};
  assign accept_s   = bus.in_valid && !skid_valid_r;
  assign out_free_s = !out_valid_r || bus.out_ready;

  // Output register and skid entry; a full skid implies a full output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_r        <= '0;
      skid_r       <= '0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r) begin
      // in_ready is low here, so the only possible move is skid -> output
      if (bus.out_ready) begin
        out_r        <= skid_r;
        skid_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      if (out_free_s) begin
        out_r       <= in_entry_s;
        out_valid_r <= 1'b1;
      end else begin
        skid_r       <= in_entry_s;
        skid_valid_r <= 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef IDU_PERF_EN
  // Accepted-entry and back-pressure counters; survive flush, wrap at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dec_cnt   <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (accept_s) perf_dec_cnt <= perf_dec_cnt + 32'd1;
      if (out_valid_r && !bus.out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.in_ready     = !skid_valid_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_pc       = out_r.pc[XLEN-1:0];
  assign bus.out_rs1      = out_r.dec.rs1[AW-1:0];
  assign bus.out_rs2      = out_r.dec.rs2[AW-1:0];
  assign bus.out_rd       = out_r.dec.rd[AW-1:0];
  assign bus.out_imm      = out_r.dec.imm[XLEN-1:0];
  assign bus.out_alu_op   = out_r.dec.alu_op;
  assign bus.out_alu_src  = out_r.dec.alu_src;
  assign bus.out_br_op    = out_r.dec.br_op;
  assign bus.out_mem_size = out_r.dec.mem_size;
  assign bus.out_flags    = out_r.dec.flags;
  assign bus.out_csr_op   = out_r.dec.csr_op;
  assign bus.out_csr_imm  = out_r.dec.csr_imm;
  assign bus.out_csr_we   = out_r.dec.csr_we;
  assign bus.out_csr_addr = out_r.dec.csr_addr;
  assign bus.out_illegal  = out_r.dec.illegal;

  // high register-index bits are dropped when AW < 5
  assign unused_reg_bits_s = ^{out_r.dec.rs1, out_r.dec.rs2, out_r.dec.rd};

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: directed + random bench for idu_stage (NR_REGS=16).
// The stage is modelled as a 2-deep FIFO of expected decode results; the
// expected result of each instruction is computed from the ISA rules.
module tb_idu_stage;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  idu_if #(.XLEN(32), .AW(4)) bus ();

`ifdef IDU_PERF_EN
  logic [31:0] perf_dec_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  idu_stage #(.NR_REGS(16), .XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef IDU_PERF_EN
    ,
    .perf_dec_cnt   (perf_dec_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [115:0] q[$];
  logic [115:0] pend;
  logic         fire_in;
  logic         fire_out;
  logic         fl_pend;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [115:0] obs();
    return {bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm,
            bus.out_alu_op, bus.out_alu_src, bus.out_br_op, bus.out_mem_size,
            bus.out_flags, bus.out_csr_op, bus.out_csr_imm, bus.out_csr_we,
            bus.out_csr_addr, bus.out_illegal};
  endfunction

  function automatic logic [3:0] arith(input logic [2:0] f3, input logic [6:0] f7, input logic is_reg);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f3 == 3'd0 && is_reg && f7 == 7'h20) return 4'd1;
    if (f3 == 3'd5 && f7 == 7'h20) return 4'd7;
    return tbl[f3];
  endfunction

  // Expected visible entry for an instruction at pc
  function automatic logic [115:0] model(input logic [31:0] pc, input logic [31:0] ins);
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [4:0] rd, rs1, rs2;
    logic [31:0] imm; logic [3:0] alu; logic src; logic [2:0] br, msz;
    logic rw, mrd, mwr, m2r, bra, jl, jr, aup, fen, ecl, ebk, mrt;
    logic [1:0] cop; logic cim, cwe, bad; logic [11:0] cad; logic [2:0] used;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
    imm = 32'd0; alu = 4'd0; src = 1'b0; br = 3'd0; msz = 3'd0;
    {rw, mrd, mwr, m2r, bra, jl, jr, aup, fen, ecl, ebk, mrt} = 12'd0;
    cop = 2'd0; cim = 1'b0; cwe = 1'b0; cad = 12'd0; bad = 1'b0; used = 3'b000;
    case (op)
      7'h37: begin imm = {ins[31:12], 12'h0}; alu = 4'd10; src = 1; rw = 1; used = 3'b100; end
      7'h17: begin imm = {ins[31:12], 12'h0}; src = 1; rw = 1; aup = 1; used = 3'b100; end
      7'h6F: begin imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); src = 1; rw = 1; jl = 1; used = 3'b100; end
      7'h67: begin imm = $signed(ins[31:20]); src = 1; rw = 1; jr = 1; used = 3'b110; end
      7'h63: begin imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); br = f3; bra = 1; used = 3'b011;
                   bad = f3 inside {3'd2, 3'd3}; end
      7'h03: begin imm = $signed(ins[31:20]); src = 1; msz = f3; mrd = 1; m2r = 1; rw = 1; used = 3'b110;
                   bad = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'h23: begin imm = $signed({ins[31:25], ins[11:7]}); src = 1; msz = f3; mwr = 1; used = 3'b011;
                   bad = f3 > 3'd2; end
      7'h13: begin imm = $signed(ins[31:20]); src = 1; rw = 1; used = 3'b110; alu = arith(f3, f7, 1'b0);
                   bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})); end
      7'h33: begin rw = 1; used = 3'b111; alu = arith(f3, f7, 1'b1);
                   bad = !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5})); end
      7'h0F: begin imm = $signed(ins[31:20]); fen = 1; end
      7'h73: begin
        if (f3 == 3'd0) begin
          if (ins[31:20] == 12'h000) ecl = 1;
          else if (ins[31:20] == 12'h001) ebk = 1;
          else if (ins[31:20] == 12'h302) mrt = 1;
          else bad = 1;
        end else if (f3 == 3'd4) bad = 1;
        else begin
          cop = f3[1:0]; cim = f3[2]; cad = ins[31:20]; alu = 4'd10; src = cim;
          imm = cim ? {27'd0, rs1} : 32'd0; rw = 1; used = cim ? 3'b100 : 3'b110;
          cwe = (cop == 2'd1) || (rs1 != 5'd0);
        end
      end
      default: bad = 1;
    endcase
    if ((used[2] && rd[4]) || (used[1] && rs1[4]) || (used[0] && rs2[4])) bad = 1;
    if (bad) begin rw = 0; mrd = 0; mwr = 0; bra = 0; jl = 0; jr = 0; cwe = 0; end
    if (rd == 5'd0) rw = 0;
    return {pc, rs1[3:0], rs2[3:0], rd[3:0], imm, alu, src, br, msz,
            rw, mrd, mwr, m2r, bra, jl, jr, aup, fen, ecl, ebk, mrt,
            cop, cim, cwe, cad, bad};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w; logic [6:0] ops [11]; int k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom();
    k = $urandom_range(0, 13);
    if (k < 11) w[6:0] = ops[k];
    else if (k < 13) w[6:0] = ops[$urandom_range(7, 10)];
    if ($urandom_range(0, 3) != 0) begin w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0; end
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: w[31:25] = w[31:25];
    endcase
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
      w[14:12] = 3'd0;
      case ($urandom_range(0, 3))
        0: w[31:20] = 12'h000;
        1: w[31:20] = 12'h001;
        2: w[31:20] = 12'h302;
        default: w[31:20] = w[31:20];
      endcase
    end
    return w;
  endfunction

  // Drive one cycle's inputs at negedge and check the current visible state
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    @(negedge clk);
    bus.in_valid = v; bus.in_pc = pc; bus.in_inst = ins; bus.out_ready = rdy; flush = fl;
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) chk("payload", obs(), q[0]);
    fire_in  = v && (q.size() < 2);
    fire_out = rdy && (q.size() > 0);
    fl_pend  = fl;
    pend     = model(pc, ins);
  endtask

  task automatic tick();
    @(posedge clk);
    if (fl_pend) q.delete();
    else begin
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back(pend);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic rdy, input logic fl);
    drive(v, pc, ins, rdy, fl);
    tick();
  endtask

  // Present one instruction and stop at the negedge where it is visible
  task automatic single(input logic [31:0] pc, input logic [31:0] ins);
    cyc(1'b1, pc, ins, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = 32'h0; bus.in_inst = 32'h0; bus.out_ready = 1'b0;
    fire_in = 1'b0; fire_out = 1'b0; fl_pend = 1'b0; pend = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_payload", obs(), 116'd0);
    rst = 1'b0;

    single(32'h100, 32'h00500093);
    chk("addi_rd", bus.out_rd, 4'd1);
    chk("addi_imm", bus.out_imm, 32'd5);
    chk("addi_alu", {bus.out_alu_op, bus.out_alu_src}, {4'd0, 1'b1});
    chk("addi_flags", {bus.out_flags, bus.out_illegal}, {12'h800, 1'b0});
    tick();

    cyc(1'b1, 32'h200, 32'h00500093, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 32'h00A00113, 1'b0, 1'b0);
    drive(1'b1, 32'h208, 32'h00F00193, 1'b0, 1'b0);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_first", bus.out_pc, 32'h200);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_second", bus.out_pc, 32'h204);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_drained", bus.out_valid, 1'b0);
    tick();

    single(32'h300, 32'h01000093);
    chk("e_x16imm", {bus.out_illegal, bus.out_flags[11]}, 2'b01);
    tick();
    single(32'h304, 32'h00000893);
    chk("e_x17", {bus.out_illegal, bus.out_flags[11]}, 2'b10);
    tick();

    single(32'h400, 32'h30002573);
    chk("csrrs", {bus.out_csr_op, bus.out_csr_we, bus.out_csr_addr, bus.out_flags[11]},
        {2'd2, 1'b0, 12'h300, 1'b1});
    tick();
    single(32'h404, 32'h30051073);
    chk("csrrw", {bus.out_csr_we, bus.out_flags[11]}, 2'b10);
    tick();

    cyc(1'b1, 32'h500, 32'h00100093, 1'b0, 1'b0);
    cyc(1'b1, 32'h504, 32'h00200093, 1'b0, 1'b0);
    drive(1'b1, 32'h508, 32'h00300093, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h600, 32'h00400093, 1'b0, 1'b1);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_ghost", bus.out_valid, 1'b0);
    tick();

    single(32'h700, 32'h00100073);
    chk("ebreak", {bus.out_flags, bus.out_illegal}, {12'h002, 1'b0});
    tick();
    single(32'h704, 32'h30200073);
    chk("mret", {bus.out_flags, bus.out_illegal}, {12'h001, 1'b0});
    tick();
    single(32'h708, 32'h10500073);
    chk("wfi", {bus.out_flags, bus.out_illegal}, {12'h000, 1'b1});
    tick();

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom(), rand_inst(),
          $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
